// File: rtl/i2c_target_mem.sv
// I2C target with an internal byte-addressable register memory.
// It oversamples SCL/SDA on clk, answers DEV_ADDR, takes a register pointer
// and write data, and returns read data with pointer auto-increment.
//
// Ports:
//   clk      - system clock, all logic on the rising edge
//   rst      - synchronous active-low reset
//   scl_i    - SCL pin level (asynchronous)
//   sda_i    - SDA pin level (asynchronous)
//   sda_oe   - 1 pulls SDA low, 0 releases it (open-drain pad)
//   busy     - high from address-match ACK until STOP, repeated START or read NACK
//   wr_pulse - one-cycle strobe when a data byte is committed to memory
//   wr_addr  - memory address of the committed byte
//   wr_data  - committed byte
module i2c_target_mem #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned MEM_DEPTH = 128,
  localparam int unsigned PW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          busy,
  output logic          wr_pulse,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRack, StWaitStop
  } state_e;

  // [0],[1] synchronizer, [2] previous value for edge detection
  logic [2:0] scl_q, sda_q;

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic          rw_q, rw_d;
  logic          ack_q, ack_d;     // ACK slot: SDA is currently being pulled for ACK
  logic [PW-1:0] ptr_q, ptr_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          wr_pulse_q, wr_pulse_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    mem_q [MEM_DEPTH];
  logic          mem_we;

  logic scl_hi, scl_rise, scl_fall, sda_s, sda_rise, sda_fall, start_det, stop_det;
  logic [7:0] byte_in;

  assign scl_hi    = scl_q[1] & scl_q[2];
  assign scl_rise  = scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] & scl_q[2];
  assign sda_s     = sda_q[1];
  assign sda_rise  = sda_q[1] & ~sda_q[2];
  assign sda_fall  = ~sda_q[1] & sda_q[2];
  assign start_det = sda_fall & scl_hi;
  assign stop_det  = sda_rise & scl_hi;
  assign byte_in   = {sh_q[6:0], sda_s};

  always_ff @(posedge clk) begin
    if (!rst) begin
      // Reset to the idle bus level so no spurious START/STOP is seen
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      state_q    <= StIdle;
      cnt_q      <= '0;
      sh_q       <= '0;
      rw_q       <= 1'b0;
      ack_q      <= 1'b0;
      ptr_q      <= '0;
      sda_oe_q   <= 1'b0;
      busy_q     <= 1'b0;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int unsigned i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sh_q       <= sh_d;
      rw_q       <= rw_d;
      ack_q      <= ack_d;
      ptr_q      <= ptr_d;
      sda_oe_q   <= sda_oe_d;
      busy_q     <= busy_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      if (mem_we) mem_q[ptr_q] <= byte_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sh_d       = sh_q;
    rw_d       = rw_q;
    ack_d      = ack_q;
    ptr_d      = ptr_q;
    sda_oe_d   = sda_oe_q;
    busy_d     = busy_q;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    mem_we     = 1'b0;

    if (start_det || stop_det) begin
      // Bus conditions override everything; a partial byte is dropped
      state_d  = start_det ? StAddr : StIdle;
      cnt_d    = '0;
      ack_d    = 1'b0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: sda_oe_d = 1'b0;

        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            sh_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = '0;
              if (state_q == StAddr) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = StAddrAck;
                  rw_d    = byte_in[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = StWaitStop;
                end
              end else if (state_q == StPtr) begin
                ptr_d   = byte_in[PW-1:0];
                state_d = StPtrAck;
              end else begin
                mem_we     = 1'b1;
                wr_pulse_d = 1'b1;
                wr_addr_d  = ptr_q;
                wr_data_d  = byte_in;
                ptr_d      = ptr_q + 1'b1;
                state_d    = StWdataAck;
              end
            end
          end
        end

        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!ack_q) begin
              sda_oe_d = 1'b1;
              ack_d    = 1'b1;
            end else begin
              ack_d    = 1'b0;
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q == StAddrAck && rw_q) begin
                // The fall that ends the ACK slot already carries the read MSB
                state_d  = StRdata;
                sda_oe_d = ~mem_q[ptr_q][7];
                sh_d     = {mem_q[ptr_q][6:0], 1'b0};
                cnt_d    = 4'd1;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end

        StRdata: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              ptr_d    = ptr_q + 1'b1;
              cnt_d    = '0;
              state_d  = StRack;
            end else begin
              sda_oe_d = ~sh_q[7];
              sh_d     = {sh_q[6:0], 1'b0};
              cnt_d    = cnt_q + 4'd1;
            end
          end
        end

        StRack: begin
          if (scl_rise) begin
            if (!sda_s) begin
              state_d = StRdata;
              sh_d    = mem_q[ptr_q];
              cnt_d   = '0;
            end else begin
              state_d = StWaitStop;
              busy_d  = 1'b0;
            end
          end
        end

        default: state_d = StIdle;
      endcase
    end
  end

  assign sda_oe   = sda_oe_q;
  assign busy     = busy_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_i2c_target_mem.sv
// Self-checking bench for i2c_target_mem: an I2C initiator drives the bus,
// a transaction-level memory/pointer model predicts every ACK, read bit, busy
// level and write strobe, and one compare process checks the DUT each cycle.
module tb_i2c_target_mem;

  localparam logic [6:0] DEV = 7'h50;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, scl_m, sda_m, sda_line;
  logic       sda_oe, busy, wr_pulse;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  assign sda_line = sda_m & ~sda_oe;

  i2c_target_mem #(.DEV_ADDR(DEV), .MEM_DEPTH(128)) dut (
    .clk     (clk),
    .rst     (rst),
    .scl_i   (scl_m),
    .sda_i   (sda_line),
    .sda_oe  (sda_oe),
    .busy    (busy),
    .wr_pulse(wr_pulse),
    .wr_addr (wr_addr),
    .wr_data (wr_data)
  );

  // Driven by the stimulus process, read by the compare process
  logic        chk_en, exp_oe, exp_busy, pin_en, rst_chk;
  logic [31:0] pin_act, pin_exp;
  string       pin_name;
  logic [6:0]  ewa [0:1023];
  logic [7:0]  ewd [0:1023];
  int          wr_head;

  // Owned by the compare process
  int         checks = 0;
  int         errors = 0;
  int         wr_tail = 0;
  logic [6:0] last_wa = '0;
  logic [7:0] last_wd = '0;

  // Behavioural model
  logic [7:0] mem_m [128];
  logic [6:0] ptr_m;
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_chk) begin
        cmp("rst_sda_oe", 32'(sda_oe), 0);
        cmp("rst_busy", 32'(busy), 0);
        cmp("rst_wr_pulse", 32'(wr_pulse), 0);
        cmp("rst_wr_addr", 32'(wr_addr), 0);
        cmp("rst_wr_data", 32'(wr_data), 0);
      end
      if (chk_en) begin
        cmp("sda_oe", 32'(sda_oe), 32'(exp_oe));
        cmp("busy", 32'(busy), 32'(exp_busy));
      end
      if (wr_pulse !== 1'b0) begin
        if (wr_tail >= wr_head) begin
          cmp("wr_pulse_unexpected", 32'(wr_pulse), 0);
        end else begin
          cmp("wr_addr", 32'(wr_addr), 32'(ewa[wr_tail]));
          cmp("wr_data", 32'(wr_data), 32'(ewd[wr_tail]));
          wr_tail++;
        end
        last_wa = wr_addr;
        last_wd = wr_data;
      end
      if (pin_en) cmp(pin_name, pin_act, pin_exp);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pin(input string nm, input logic [31:0] act, input logic [31:0] exp);
    pin_name = nm;
    pin_act  = act;
    pin_exp  = exp;
    pin_en   = 1'b1;
    tick(1);
    pin_en   = 1'b0;
  endtask

  // One SCL period starting and ending with SCL low; checks the high phase
  task automatic bit_cycle(input logic m, input logic e_oe, input logic e_busy,
                           output logic ln);
    sda_m = m;
    tick(5);
    scl_m = 1'b1;
    tick(5);
    exp_oe   = e_oe;
    exp_busy = e_busy;
    chk_en   = 1'b1;
    tick(3);
    ln     = sda_line;
    chk_en = 1'b0;
    tick(1);
    scl_m = 1'b0;
    tick(5);
  endtask

  task automatic start_cond();
    if (!scl_m) begin
      sda_m = 1'b1;
      tick(5);
      scl_m = 1'b1;
    end
    tick(8);
    sda_m = 1'b0;
    tick(8);
    scl_m = 1'b0;
    tick(5);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0;
    tick(5);
    scl_m = 1'b1;
    tick(8);
    sda_m = 1'b1;
    tick(8);
    exp_oe   = 1'b0;
    exp_busy = 1'b0;
    chk_en   = 1'b1;
    tick(4);
    chk_en   = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e_ack,
                           input logic busy_pre, input logic busy_post);
    logic ln;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], 1'b0, (i == 0) ? busy_post : busy_pre, ln);
    bit_cycle(1'b1, e_ack, busy_post, ln);
  endtask

  task automatic recv_byte(input logic [7:0] e, input logic ack, output logic [7:0] got);
    logic ln;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, ~e[i], 1'b1, ln);
      got[i] = ln;
    end
    bit_cycle(~ack, 1'b0, ack, ln);
  endtask

  task automatic wr_txn(input logic [7:0] p, input int n, input logic do_stop);
    start_cond();
    send_byte({DEV, 1'b0}, 1'b1, 1'b0, 1'b1);
    send_byte(p, 1'b1, 1'b1, 1'b1);
    ptr_m = p[6:0];
    for (int k = 0; k < n; k++) begin
      ewa[wr_head] = ptr_m;
      ewd[wr_head] = wbuf[k];
      wr_head++;
      mem_m[ptr_m] = wbuf[k];
      ptr_m = ptr_m + 7'd1;
      send_byte(wbuf[k], 1'b1, 1'b1, 1'b1);
    end
    if (do_stop) begin
      stop_cond();
      pin("wr_missing", 32'(wr_head - wr_tail), 0);
    end
  endtask

  // Current-address read of n bytes; ACK all but the last. Caller ends with STOP.
  task automatic rd_txn(input int n);
    logic [7:0] got;
    start_cond();
    send_byte({DEV, 1'b1}, 1'b1, 1'b0, 1'b1);
    for (int k = 0; k < n; k++) begin
      recv_byte(mem_m[ptr_m], k != n - 1, got);
      rbuf[k] = got;
      ptr_m = ptr_m + 7'd1;
    end
  endtask

  initial begin : stim
    logic [7:0] e;
    logic       ln;
    logic [6:0] a;
    int         kind, n;

    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    chk_en = 1'b0; exp_oe = 1'b0; exp_busy = 1'b0; pin_en = 1'b0; rst_chk = 1'b0;
    pin_act = '0; pin_exp = '0; pin_name = ""; wr_head = 0; ptr_m = '0;
    for (int i = 0; i < 128; i++) mem_m[i] = '0;

    tick(3);
    rst_chk = 1'b1;
    tick(1);
    rst_chk = 1'b0;
    rst = 1'b1;
    tick(5);

    // Directed writes and reads
    wbuf[0] = 8'h77;
    wr_txn(8'h11, 1, 1'b1);
    wbuf[0] = 8'h5A;
    wr_txn(8'h10, 1, 1'b1);
    pin("lit_wr_addr", 32'(last_wa), 32'h10);
    pin("lit_wr_data", 32'(last_wd), 32'h5A);

    wr_txn(8'h10, 0, 1'b0);
    rd_txn(1);
    stop_cond();
    pin("lit_rd_5a", 32'(rbuf[0]), 32'h5A);
    rd_txn(1);
    stop_cond();
    pin("lit_rd_ptr11", 32'(rbuf[0]), 32'h77);

    // Burst with pointer wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22;
    wr_txn(8'h7F, 2, 1'b1);
    pin("lit_wrap_addr", 32'(last_wa), 32'h00);
    pin("lit_wrap_data", 32'(last_wd), 32'h22);
    wr_txn(8'h7F, 0, 1'b0);
    rd_txn(2);
    stop_cond();
    pin("lit_burst0", 32'(rbuf[0]), 32'h11);
    pin("lit_burst1", 32'(rbuf[1]), 32'h22);

    // Address mismatch, then a valid write
    start_cond();
    send_byte(8'h42, 1'b0, 1'b0, 1'b0);
    send_byte(8'h99, 1'b0, 1'b0, 1'b0);
    stop_cond();
    wbuf[0] = 8'h33;
    wr_txn(8'h05, 1, 1'b1);

    // STOP after four data bits: no write
    wr_txn(8'h30, 0, 1'b0);
    for (int i = 0; i < 4; i++) bit_cycle(i[0], 1'b0, 1'b1, ln);
    stop_cond();
    pin("abort_wr_missing", 32'(wr_head - wr_tail), 0);
    wr_txn(8'h30, 0, 1'b0);
    rd_txn(1);
    stop_cond();

    // Randomized transactions
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      if (kind == 0) begin
        for (int k = 0; k < n; k++) wbuf[k] = 8'($urandom);
        wr_txn(8'($urandom_range(0, 255)), n, 1'b1);
      end else if (kind == 1) begin
        wr_txn(8'($urandom_range(0, 255)), 0, 1'b0);
        rd_txn(n);
        stop_cond();
      end else if (kind == 2) begin
        rd_txn(n);
        stop_cond();
      end else begin
        a = 7'($urandom_range(0, 127));
        if (a == DEV) a = a ^ 7'h01;
        start_cond();
        send_byte({a, 1'($urandom)}, 1'b0, 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b0, 1'b0, 1'b0);
        stop_cond();
      end
    end

    // Reset in the middle of a read byte
    start_cond();
    send_byte({DEV, 1'b1}, 1'b1, 1'b0, 1'b1);
    e = mem_m[ptr_m];
    for (int i = 7; i >= 5; i--) bit_cycle(1'b1, ~e[i], 1'b1, ln);
    rst = 1'b0;
    tick(1);
    rst_chk = 1'b1;
    tick(1);
    rst_chk = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 128; i++) mem_m[i] = '0;
    ptr_m = '0;
    sda_m = 1'b1;
    tick(5);
    scl_m = 1'b1;
    tick(10);
    wr_txn(8'h10, 0, 1'b0);
    rd_txn(1);
    stop_cond();
    pin("lit_after_rst", 32'(rbuf[0]), 32'h00);
    pin("final_wr_missing", 32'(wr_head - wr_tail), 0);

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
